// File: rtl/mips_mem_pkg.sv
// Shared definitions for the mips_cpu_harvard memory responder.
//   mem_state_e        : responder phase (loader, CPU running, CPU halted)
//   *_BASE_DEFAULT     : default byte addresses of word 0 of each memory
//   NOP                : value returned for any invalid fetch or read
//   word_index/word_ok : byte address -> word index, and alignment/range test
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } mem_state_e;

  localparam logic [31:0] INSTR_BASE_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] DATA_BASE_DEFAULT  = 32'h00000000;
  localparam logic [31:0] NOP                = 32'h00000000;

  // Addresses below base wrap to a huge index, so one range test covers both sides.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic word_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input int unsigned depth);
    return (addr[1:0] == 2'b00) && (word_index(addr, base) < depth);
  endfunction

endpackage

// File: rtl/mips_word_ram.sv
// Generic DEPTH x 32 word RAM: asynchronous read, synchronous write.
//   clk   : write clock
//   raddr : read word index; out-of-range returns NOP
//   rdata : read data (combinational)
//   we    : write enable; writes to out-of-range indices are dropped
//   waddr : write word index
//   wdata : write data
// Contents are not reset.
module mips_word_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];
  logic        rd_hit;
  logic        wr_hit;

  assign rd_hit = raddr < 32'(DEPTH);
  assign wr_hit = waddr < 32'(DEPTH);
  assign rdata  = rd_hit ? mem[raddr[AW-1:0]] : NOP;

  always_ff @(posedge clk) begin
    if (we && wr_hit) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mips_harvard_mem_responder.sv
// Responder side of the mips_cpu_harvard memory buses.
//   clk, reset       : clock, asynchronous active-high reset
//   init_mem, init_mem_addr, init_instr : instruction loader (word index + data)
//   active           : CPU active flag; a registered 1->0 halts the CPU
//   clk_enable       : CPU clock enable, high only in RUN
//   instr_active     : high only in RUN
//   instr_address / instr_readdata : fetch bus, combinational read
//   data_address, data_read, data_write, data_writedata / data_readdata : data bus
//   err              : sticky protocol/range error, cleared only by reset
//   words_loaded     : saturating count of init writes since entering LOAD
//   dbg_state        : current phase, for observation
// Handshake: no valid/ready; a strobe (init_mem, data_read, data_write) is a
// request for that single cycle. Reads answer in the same cycle, writes land at
// the next rising edge. All registered outputs change only on that edge.
module mips_harvard_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          INSTR_WORDS = 256,
  parameter int          DATA_WORDS  = 256,
  parameter logic [31:0] INSTR_BASE  = INSTR_BASE_DEFAULT,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_mem,
  input  logic [31:0] init_mem_addr,
  input  logic [31:0] init_instr,
  input  logic        active,
  output logic        clk_enable,
  output logic        instr_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        err,
  output logic [15:0] words_loaded,
  output mem_state_e  dbg_state
);

  mem_state_e  state;
  logic        init_mem_q;
  logic        active_q;

  logic        instr_ok;
  logic        data_ok;
  logic        load_ok;
  logic        run_err;
  logic        imem_we;
  logic        dmem_we;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_rdata;

  assign instr_ok = word_ok(instr_address, INSTR_BASE, INSTR_WORDS);
  assign data_ok  = word_ok(data_address, DATA_BASE, DATA_WORDS);
  assign load_ok  = init_mem_addr < 32'(INSTR_WORDS);

  assign imem_we  = (state == ST_LOAD) && init_mem && load_ok;
  assign dmem_we  = (state == ST_RUN) && data_write && data_ok;

  // Any of these during RUN marks a bus protocol or range violation.
  assign run_err  = init_mem || !instr_ok || (data_read && !data_ok) ||
                    (data_write && !data_ok) || (data_read && data_write);

  mips_word_ram #(.DEPTH(INSTR_WORDS)) u_imem (
    .clk   (clk),
    .raddr (word_index(instr_address, INSTR_BASE)),
    .rdata (imem_rdata),
    .we    (imem_we),
    .waddr (init_mem_addr),
    .wdata (init_instr)
  );

  mips_word_ram #(.DEPTH(DATA_WORDS)) u_dmem (
    .clk   (clk),
    .raddr (word_index(data_address, DATA_BASE)),
    .rdata (dmem_rdata),
    .we    (dmem_we),
    .waddr (word_index(data_address, DATA_BASE)),
    .wdata (data_writedata)
  );

  // Read-during-write shows the pre-write word because the RAM write is registered.
  assign instr_readdata = instr_ok ? imem_rdata : NOP;
  assign data_readdata  = (data_read && data_ok) ? dmem_rdata : NOP;
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_LOAD;
      clk_enable   <= 1'b0;
      instr_active <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 16'd0;
      init_mem_q   <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      init_mem_q <= init_mem;
      case (state)
        ST_LOAD: begin
          if (init_mem) begin
            if (!load_ok) begin
              err <= 1'b1;
            end else if (words_loaded != 16'hFFFF) begin
              words_loaded <= words_loaded + 16'd1;
            end
          end else if (init_mem_q && (words_loaded != 16'd0)) begin
            state        <= ST_RUN;
            clk_enable   <= 1'b1;
            instr_active <= 1'b1;
            // Forget any stale active sample so a new run needs a fresh 1->0.
            active_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          active_q <= active;
          if (run_err) begin
            err <= 1'b1;
          end
          if (active_q && !active) begin
            state        <= ST_HALT;
            clk_enable   <= 1'b0;
            instr_active <= 1'b0;
          end
        end
        ST_HALT: begin
          if (init_mem) begin
            state        <= ST_LOAD;
            words_loaded <= 16'd0;
          end
        end
        default: begin
          state        <= ST_LOAD;
          clk_enable   <= 1'b0;
          instr_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
module tb_mips_harvard_mem_responder;
  import mips_mem_pkg::*;

  localparam logic [31:0] IB = 32'hBFC00000;
  localparam int          NW = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        init_mem;
  logic [31:0] init_mem_addr;
  logic [31:0] init_instr;
  logic        active;
  logic        clk_enable;
  logic        instr_active;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        err;
  logic [15:0] words_loaded;
  mem_state_e  dbg_state;

  mips_harvard_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .init_mem       (init_mem),
    .init_mem_addr  (init_mem_addr),
    .init_instr     (init_instr),
    .active         (active),
    .clk_enable     (clk_enable),
    .instr_active   (instr_active),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .err            (err),
    .words_loaded   (words_loaded),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  mem_state_e  m_state;
  logic        m_err;
  logic [15:0] m_wl;
  logic        m_prev_init;
  logic        m_last_active;
  logic [31:0] m_imem [NW];
  bit          m_iknown [NW];
  logic [31:0] m_dmem [NW];
  bit          m_dknown [NW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit addr_valid(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return (off % 4 == 0) && (off / 4 < NW);
  endfunction

  task automatic model_reset();
    m_state = ST_LOAD;
    m_err = 1'b0;
    m_wl = 16'd0;
    m_prev_init = 1'b0;
    m_last_active = 1'b0;
  endtask

  // Combinational read paths checked mid-cycle against the model memories.
  task automatic check_comb();
    logic [31:0] idx;
    if (addr_valid(instr_address, IB)) begin
      idx = (instr_address - IB) / 4;
      if (m_iknown[idx[7:0]]) check("instr_rd", instr_readdata, m_imem[idx[7:0]]);
    end else begin
      check("instr_nop", instr_readdata, 32'h0);
    end
    if (data_read && addr_valid(data_address, 32'h0)) begin
      idx = data_address / 4;
      if (m_dknown[idx[7:0]]) check("data_rd", data_readdata, m_dmem[idx[7:0]]);
    end else begin
      check("data_zero", data_readdata, 32'h0);
    end
  endtask

  // Apply one rising edge's worth of behaviour to the model; queue expected outputs.
  task automatic model_edge();
    bit i_ok, d_ok;
    logic [31:0] di;
    i_ok = addr_valid(instr_address, IB);
    d_ok = addr_valid(data_address, 32'h0);
    di = data_address / 4;
    case (m_state)
      ST_LOAD: begin
        if (init_mem) begin
          if (init_mem_addr < NW) begin
            m_imem[init_mem_addr[7:0]] = init_instr;
            m_iknown[init_mem_addr[7:0]] = 1'b1;
            if (m_wl < 16'hFFFF) m_wl = m_wl + 16'd1;
          end else m_err = 1'b1;
        end else if (m_prev_init && m_wl > 0) begin
          m_state = ST_RUN;
          m_last_active = 1'b0;
        end
      end
      ST_RUN: begin
        if (init_mem || !i_ok || ((data_read || data_write) && !d_ok) || (data_read && data_write))
          m_err = 1'b1;
        if (data_write && d_ok) begin
          m_dmem[di[7:0]] = data_writedata;
          m_dknown[di[7:0]] = 1'b1;
        end
        if (m_last_active && !active) m_state = ST_HALT;
        m_last_active = active;
      end
      default: begin
        if (init_mem) begin
          m_state = ST_LOAD;
          m_wl = 16'd0;
        end
      end
    endcase
    m_prev_init = init_mem;
    exp_q.push_back({11'd0, m_state, (m_state == ST_RUN), (m_state == ST_RUN), m_err, m_wl});
  endtask

  task automatic check_regs();
    logic [31:0] e;
    e = exp_q.pop_front();
    check("state", 32'(dbg_state), 32'(e[20:19]));
    check("clk_enable", 32'(clk_enable), 32'(e[18]));
    check("instr_active", 32'(instr_active), 32'(e[17]));
    check("err", 32'(err), 32'(e[16]));
    check("words_loaded", 32'(words_loaded), 32'(e[15:0]));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set by the caller after posedge+1; returns at next posedge+1.
  task automatic cycle();
    @(negedge clk);
    check_comb();
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_clk_enable", 32'(clk_enable), 32'h0);
    check("rst_instr_active", 32'(instr_active), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_words_loaded", 32'(words_loaded), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_LOAD));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    init_mem = 1'b0;
    data_read = 1'b0;
    data_write = 1'b0;
  endtask

  logic [31:0] rnd_idx;

  initial begin
    init_mem = 1'b0; init_mem_addr = '0; init_instr = '0; active = 1'b0;
    instr_address = IB; data_address = '0; data_read = 1'b0; data_write = 1'b0;
    data_writedata = '0;
    for (int i = 0; i < NW; i++) begin m_iknown[i] = 1'b0; m_dknown[i] = 1'b0; end
    do_reset();

    // Load two words, drop init_mem, enter RUN.
    init_mem = 1'b1; init_mem_addr = 0; init_instr = 32'h8C0C0000; cycle();
    init_mem_addr = 1; init_instr = 32'h01800008; cycle();
    init_mem = 1'b0; cycle();
    check("load_words", 32'(words_loaded), 32'd2);
    check("load_run_ce", 32'(clk_enable), 32'd1);
    instr_address = IB + 32'd4; cycle();
    check("instr_word1", instr_readdata, 32'h01800008);

    // Data write then read back.
    active = 1'b1;
    data_write = 1'b1; data_address = 32'h10; data_writedata = 32'd4; cycle();
    data_write = 1'b0; data_read = 1'b1; #1;
    check("dmem4_read", data_readdata, 32'd4);
    check("dmem4_err", 32'(err), 32'd0);
    cycle();

    // Random legal traffic; indices 2 and 4 are reserved for later directed checks.
    for (int n = 0; n < 200; n++) begin
      instr_address = IB + 4 * $urandom_range(0, 1);
      do rnd_idx = $urandom_range(0, NW - 1); while (rnd_idx == 2 || rnd_idx == 4);
      data_address = rnd_idx * 4;
      data_writedata = $urandom;
      case ($urandom_range(0, 2))
        0: begin data_write = 1'b1; data_read = 1'b0; end
        1: begin data_write = 1'b0; data_read = 1'b1; end
        default: begin data_write = 1'b0; data_read = 1'b0; end
      endcase
      cycle();
    end

    // Simultaneous read and write: old value this cycle, new value next.
    data_read = 1'b0; data_write = 1'b1; data_address = 32'h8; data_writedata = 32'h11; cycle();
    data_read = 1'b1; data_writedata = 32'h22; #1;
    check("rw_pre_value", data_readdata, 32'h11);
    cycle();
    data_write = 1'b0; #1;
    check("rw_post_value", data_readdata, 32'h22);
    check("rw_err", 32'(err), 32'd1);
    cycle();
    data_read = 1'b0;

    // Halt on registered active fall.
    active = 1'b0; cycle();
    check("halt_ce", 32'(clk_enable), 32'd0);
    check("halt_state", 32'(dbg_state), 32'(ST_HALT));
    data_write = 1'b1; data_address = 32'h10; data_writedata = 32'd99; cycle();
    data_write = 1'b0;
    init_mem = 1'b1; init_mem_addr = 7; init_instr = $urandom; cycle();
    check("halt_to_load_state", 32'(dbg_state), 32'(ST_LOAD));
    check("halt_to_load_wl", 32'(words_loaded), 32'd0);
    for (int i = 0; i < NW; i++) begin
      init_mem_addr = i; init_instr = $urandom; cycle();
    end
    init_mem = 1'b0; cycle();
    check("reload_words", 32'(words_loaded), 32'd256);

    // Asynchronous reset in the middle of RUN.
    active = 1'b1; instr_address = IB; cycle();
    #3 reset = 1'b1;
    #1;
    check("midrst_ce", 32'(clk_enable), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_LOAD));
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    init_mem = 1'b1; init_mem_addr = 0; init_instr = $urandom; cycle();
    init_mem = 1'b0; cycle();
    data_read = 1'b1; data_address = 32'h10; instr_address = IB + 32'd20; #1;
    check("dmem4_retained", data_readdata, 32'd4);
    cycle();
    data_read = 1'b0;

    // Fetch below the instruction base.
    instr_address = 32'h0; #1;
    check("instr_low_nop", instr_readdata, 32'h0);
    check("instr_low_err_before", 32'(err), 32'd0);
    cycle();
    check("instr_low_err_after", 32'(err), 32'd1);

    // Fully random traffic including illegal accesses and phase changes.
    for (int n = 0; n < 400; n++) begin
      init_mem = ($urandom_range(0, 5) == 0);
      init_mem_addr = $urandom_range(0, 300);
      init_instr = $urandom;
      active = ($urandom_range(0, 3) != 0);
      instr_address = ($urandom_range(0, 5) == 0) ? $urandom : IB + 4 * $urandom_range(0, NW - 1);
      data_address = ($urandom_range(0, 5) == 0) ? $urandom : 4 * $urandom_range(0, NW - 1);
      data_writedata = $urandom;
      data_read = $urandom_range(0, 1);
      data_write = $urandom_range(0, 1);
      cycle();
    end
    idle_inputs();

    // Out-of-range load, then a fall with nothing loaded stays in LOAD.
    do_reset();
    init_mem = 1'b1; init_mem_addr = 300; init_instr = $urandom; cycle();
    check("load_oob_err", 32'(err), 32'd1);
    check("load_oob_wl", 32'(words_loaded), 32'd0);
    init_mem = 1'b0; cycle();
    cycle();
    check("empty_fall_state", 32'(dbg_state), 32'(ST_LOAD));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_harvard_mem_responder.md
Name: mips_harvard_mem_responder

Overview:
- Responder side of the mips_cpu_harvard memory interface: instruction ROM/RAM plus data RAM answering the CPU's instr_* and data_* buses.
- Owns the init loader (init_mem/init_mem_addr/init_instr), gates the CPU via clk_enable, and detects CPU halt.
- Synthesizable memory model for simulation benches and FPGA bring-up.

Parameters:
- INSTR_WORDS, 256, instruction memory depth in 32-bit words.
- DATA_WORDS, 256, data memory depth in 32-bit words.
- INSTR_BASE, 32'hBFC00000, byte address of instruction word 0 (CPU reset vector).
- DATA_BASE, 32'h00000000, byte address of data word 0.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- init_mem  in  1  loader enable; high = write init_instr this cycle.
- init_mem_addr  in  32  instruction word index for the load.
- init_instr  in  32  instruction word to load.
- active  in  1  CPU active output.
- clk_enable  out  1  CPU clock enable.
- instr_active  out  1  high while in RUN.
- instr_address  in  32  CPU fetch byte address.
- instr_readdata  out  32  fetched word (combinational).
- data_address  in  32  CPU data byte address.
- data_read  in  1  data read strobe.
- data_write  in  1  data write strobe.
- data_writedata  in  32  write data.
- data_readdata  out  32  read data (combinational).
- err  out  1  sticky protocol/range error.
- words_loaded  out  16  count of init writes since entering LOAD.

Behaviour:
- Reset (async): state LOAD, clk_enable=0, instr_active=0, err=0, words_loaded=0. Memory contents not reset.
- States: LOAD, RUN, HALT.
- LOAD: clk_enable=0.
  - Each cycle with init_mem=1 writes init_instr to imem[init_mem_addr] at the rising edge and increments words_loaded, saturating at 16'hFFFF.
  - init_mem_addr >= INSTR_WORDS: no write, err set, count unchanged.
  - init_mem 1->0 with words_loaded>0 -> RUN next cycle. Falling with words_loaded=0 stays in LOAD.
- RUN: clk_enable=1, instr_active=1.
  - active sampled 1 then 0 on a later edge (registered falling edge) -> HALT. clk_enable drops the cycle after the fall is sampled.
  - init_mem=1 in RUN -> ignored, err set.
- HALT: clk_enable=0, memory readable by the bench.
  - init_mem=1 -> LOAD with words_loaded cleared. The first init write occurs in LOAD the following cycle.
- Instruction read, combinational:
  - Index = (instr_address-INSTR_BASE)>>2.
  - Misaligned (instr_address[1:0]!=0) or index >= INSTR_WORDS -> instr_readdata=32'h0 (nop). err set at the next edge only while in RUN.
- Data read, combinational:
  - Index = (data_address-DATA_BASE)>>2. data_readdata=dmem[index] whenever data_read=1 and in range, else 32'h0.
  - Out-of-range or misaligned with data_read=1 in RUN -> err.
- Data write: single-cycle. When data_write=1 and in range in RUN, dmem[index]<=data_writedata at the rising edge. Out-of-range or misaligned -> no write, err.
- data_read && data_write together: write performed, data_readdata shows pre-write value that cycle, err set.
- Strobes in LOAD/HALT: ignored, no err.
- err is cleared only by reset.
- Reset mid-RUN: immediately returns to LOAD with clk_enable=0. imem and dmem are retained.

Decomposition:
- Shared package mips_mem_pkg:
  - state enum (LOAD/RUN/HALT).
  - INSTR_BASE/DATA_BASE defaults.
  - word-index helper function and NOP constant.
- Sub-module mips_word_ram:
  - generic DEPTH x 32 RAM, async read, sync write, range-checked.
  - instantiated twice (imem, dmem).

Test Plan:
- Reset then load init_mem_addr=0 -> 32'h8C0C0000 and 1 -> 32'h01800008, drop init_mem -> words_loaded=2, RUN next cycle, clk_enable=1. instr_address=32'hBFC00004 gives 32'h01800008.
- RUN, data_write=1, data_address=32'h10, data_writedata=32'd4. Next cycle data_read=1 same address -> data_readdata=32'd4, err=0.
- instr_address=32'h00000000 (below INSTR_BASE) in RUN -> instr_readdata=0, err=1 after the edge.
- data_read=1 and data_write=1 together, address 32'h8 holding 32'h11, writedata 32'h22 -> readdata 32'h11 that cycle, then 32'h22. err=1.
- active 1->0 in RUN -> HALT, clk_enable=0 one cycle later. Then init_mem=1 -> LOAD with words_loaded=0.
- Assert reset mid-RUN (async, between edges) -> clk_enable=0 immediately, state LOAD. Previously written dmem[4]=32'd4 still reads back after re-entering RUN.
